// File: rtl/spi_cfg_seq_if.sv
// Bundle of SPI-master and command-port signals used by spi_cfg_seq.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface spi_cfg_seq_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 16
) ();
  logic             spi_start_o;
  logic [ADR_W-1:0] spi_adr;
  logic [DAT_W-1:0] spi_dat;
  logic             spi_rw;
  logic [7:0]       spi_clk_pre;
  logic             spi_busy;
  logic [DAT_W-1:0] spi_rd_dat;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_dat;
  logic             cmd_rw;
  logic             reinit;
  logic             rd_valid;
  logic [DAT_W-1:0] rd_dat;
  logic             done_o;
  logic             err_o;
  logic [2:0]       state_o;

  modport master (
    output spi_start_o, spi_adr, spi_dat, spi_rw, spi_clk_pre,
           cmd_ready, rd_valid, rd_dat, done_o, err_o, state_o,
    input  spi_busy, spi_rd_dat, cmd_valid, cmd_adr, cmd_dat, cmd_rw, reinit
  );

  modport slave (
    input  spi_start_o, spi_adr, spi_dat, spi_rw, spi_clk_pre,
           cmd_ready, rd_valid, rd_dat, done_o, err_o, state_o,
    output spi_busy, spi_rd_dat, cmd_valid, cmd_adr, cmd_dat, cmd_rw, reinit
  );
endinterface

// File: rtl/spi_cfg_seq.sv
// SPI configuration sequencer: plays an init table after a power-up delay, then serves run-time commands.
// Define SPI_CFG_TIMEOUT_EN to add the busy-handshake watchdog and the ERR state.
module spi_cfg_seq #(
  parameter int NUM_REGS       = 4,
  parameter int ADR_W          = 16,
  parameter int DAT_W          = 16,
  parameter logic [NUM_REGS*(ADR_W+DAT_W)-1:0] INIT_TABLE = '0,
  parameter int WAIT_CYCLES    = 12500000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLK_PRE        = 10
) (
  input  logic          aclk,
  input  logic          aresetn,
  spi_cfg_seq_if.master bus
);

  localparam int ENT_W  = ADR_W + DAT_W;
  localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  if (NUM_REGS < 1) begin : g_bad_num_regs
    $error("spi_cfg_seq: NUM_REGS must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_cfg_seq: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_ACK   = 3'd3,
    ST_XFER  = 3'd4,
    ST_IDLE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_init;
  logic              w_accept, w_fall, w_reinit, w_wd_exp;
  logic [ENT_W-1:0]  w_entry;

  assign w_entry = INIT_TABLE[int'(r_idx)*ENT_W +: ENT_W];

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave a latch behind.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fall      = 1'b0;
    w_reinit    = 1'b0;
    case (r_state)
      ST_RESET: if (r_wait_cnt == WCNT_W'(WAIT_CYCLES) && !bus.spi_busy) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (bus.spi_busy)  w_state_nxt = ST_XFER;
        else if (w_wd_exp) w_state_nxt = ST_ERR;
      end
      ST_XFER: begin
        if (!bus.spi_busy) begin
          w_fall      = 1'b1;
          w_state_nxt = (r_init && r_idx != LAST_IDX) ? ST_LOAD : ST_IDLE;
        end else if (w_wd_exp) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_IDLE: begin
        // reinit outranks a command presented in the same cycle
        if (bus.reinit) begin
          w_reinit    = 1'b1;
          w_state_nxt = ST_LOAD;
        end else if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_ERR: begin
        if (bus.reinit) begin
          w_reinit    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!aresetn) begin
      r_state      <= ST_RESET;
      r_wait_cnt   <= '0;
      r_idx        <= '0;
      r_init       <= 1'b0;
      bus.spi_adr  <= '0;
      bus.spi_dat  <= '0;
      bus.spi_rw   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_dat   <= '0;
      bus.done_o   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      bus.rd_valid <= 1'b0;
      if (r_state == ST_RESET && r_wait_cnt != WCNT_W'(WAIT_CYCLES))
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      if (r_state == ST_RESET && w_state_nxt == ST_LOAD) begin
        r_idx  <= '0;
        r_init <= 1'b1;
      end
      if (w_reinit) begin
        r_idx      <= '0;
        r_init     <= 1'b1;
        bus.done_o <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        bus.spi_adr <= w_entry[ENT_W-1 -: ADR_W];
        bus.spi_dat <= w_entry[DAT_W-1:0];
        bus.spi_rw  <= 1'b0;
      end
      if (w_accept) begin
        bus.spi_adr <= bus.cmd_adr;
        bus.spi_dat <= bus.cmd_dat;
        bus.spi_rw  <= bus.cmd_rw;
        r_init      <= 1'b0;
      end
      if (w_fall) begin
        if (bus.spi_rw) begin
          bus.rd_dat   <= bus.spi_rd_dat;
          bus.rd_valid <= 1'b1;
        end
        if (r_init) begin
          if (r_idx == LAST_IDX) begin
            bus.done_o <= 1'b1;
            r_init     <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
      end
    end
  end

`ifdef SPI_CFG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_wd;
  logic            r_err;

  // Watchdog is cleared in START so it reads 0 on ACK's first cycle
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_START)
        r_wd <= '0;
      else if ((r_state == ST_ACK || r_state == ST_XFER) && !w_wd_exp)
        r_wd <= r_wd + TO_W'(1);
      if (w_reinit)
        r_err <= 1'b0;
      else if (w_state_nxt == ST_ERR)
        r_err <= 1'b1;
    end
  end

  assign w_wd_exp   = (r_wd == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus.err_o  = r_err;
`else
  assign w_wd_exp   = 1'b0;
  assign bus.err_o  = 1'b0;
`endif

  // Gated with aresetn so a reset aborts the strobe in the cycle it is asserted
  assign bus.spi_start_o = aresetn && (r_state == ST_START);
  assign bus.cmd_ready   = aresetn && (r_state == ST_IDLE);
  assign bus.spi_clk_pre = 8'(CLK_PRE);
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Scoreboard bench for spi_cfg_seq: expected SPI transfers and read results are queued when
// stimulus is driven and checked as the sequencer issues them. Timeout scenario needs SPI_CFG_TIMEOUT_EN.
module tb_spi_cfg_seq;

  localparam logic [127:0] TABLE = {32'h0004_0000, 32'h0003_0002, 32'h0002_000D, 32'h0001_0000};

  typedef struct packed {
    logic        rw;
    logic [15:0] adr;
    logic [15:0] dat;
  } xfer_t;

  logic aclk = 1'b0;
  logic aresetn;

  spi_cfg_seq_if #(.ADR_W(16), .DAT_W(16)) bus ();

  spi_cfg_seq #(
    .NUM_REGS(4), .ADR_W(16), .DAT_W(16), .INIT_TABLE(TABLE),
    .WAIT_CYCLES(16), .TIMEOUT_CYCLES(8), .CLK_PRE(10)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  xfer_t       exp_q[$];
  logic [15:0] rd_q[$];
  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  int n_starts  = 0;
  int n_rd      = 0;
  int first_start = -1;
  bit m_hold  = 1'b0;
  bit m_never = 1'b0;

  // Monitor + master model, both on the falling edge; the master keeps busy high 3 cycles per start
  initial begin
    int m_cnt;
    xfer_t e;
    logic [15:0] r;
    m_cnt = 0;
    bus.spi_busy = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (bus.spi_start_o === 1'b1) begin
        n_starts++;
        if (first_start < 0) first_start = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_start: rw=%0b adr=%h dat=%h, no transfer expected", bus.spi_rw, bus.spi_adr, bus.spi_dat);
        end else begin
          e = exp_q.pop_front();
          if ({bus.spi_rw, bus.spi_adr, bus.spi_dat} !== e) begin
            fails++;
            $display("FAIL xfer: got rw=%0b adr=%h dat=%h, need rw=%0b adr=%h dat=%h",
                     bus.spi_rw, bus.spi_adr, bus.spi_dat, e.rw, e.adr, e.dat);
          end
        end
      end
      if (bus.rd_valid === 1'b1) begin
        n_rd++;
        tests_run++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rd_valid: rd_dat=%h", bus.rd_dat);
        end else begin
          r = rd_q.pop_front();
          if (bus.rd_dat !== r) begin
            fails++;
            $display("FAIL rd_dat: got %h need %h", bus.rd_dat, r);
          end
        end
      end
      if (m_cnt > 0) m_cnt--;
      if (bus.spi_start_o === 1'b1 && !m_never) m_cnt = 3;
      bus.spi_busy = m_hold || (m_cnt > 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic push_table();
    xfer_t e;
    logic [127:0] t;
    t = TABLE;
    for (int i = 0; i < 4; i++) begin
      e.rw  = 1'b0;
      e.adr = t[i*32+16 +: 16];
      e.dat = t[i*32 +: 16];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (bus.state_o !== s && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (bus.state_o !== s) begin
      fails++;
      $display("FAIL %s: state_o=%0d need %0d within %0d cycles", name, bus.state_o, s, budget);
    end
  endtask

  task automatic issue_cmd(input logic rw, input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{rw: rw, adr: a, dat: d});
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_adr   = a;
    bus.cmd_dat   = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({bus.spi_start_o, bus.cmd_ready, bus.rd_valid, bus.done_o, bus.err_o, bus.state_o} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: start/ready/rdv/done/err/state=%b need 00000000",
               {bus.spi_start_o, bus.cmd_ready, bus.rd_valid, bus.done_o, bus.err_o, bus.state_o});
    end
    tests_run++;
    if ({bus.spi_adr, bus.spi_dat, bus.spi_rw, bus.rd_dat} !== 49'h0) begin
      fails++;
      $display("FAIL reset_data: adr=%h dat=%h rw=%b rd_dat=%h need all 0", bus.spi_adr, bus.spi_dat, bus.spi_rw, bus.rd_dat);
    end
    tests_run++;
    if (bus.spi_clk_pre !== 8'd10) begin
      fails++;
      $display("FAIL clk_pre: got %0d need 10", bus.spi_clk_pre);
    end
  endtask

  task automatic test_powerup();
    int t_rel;
    push_table();
    n_starts = 0;
    first_start = -1;
    aresetn = 1'b1;
    t_rel = cyc;
    wait_state(3'd5, 200, "powerup_idle");
    tests_run++;
    if (first_start - t_rel < 16 || first_start - t_rel > 20) begin
      fails++;
      $display("FAIL powerup_delay: first start %0d cycles after reset, need 16..20", first_start - t_rel);
    end
    tests_run++;
    if (n_starts !== 4 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL powerup_count: %0d starts, %0d left in queue, need 4 and 0", n_starts, exp_q.size());
    end
    tests_run++;
    if (bus.done_o !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL powerup_done: done_o=%b cmd_ready=%b need 1 1", bus.done_o, bus.cmd_ready);
    end
  endtask

  task automatic test_busy_hold();
    int t_rel;
    aresetn = 1'b0;
    m_hold = 1'b1;
    repeat (2) tick();
    push_table();
    n_starts = 0;
    first_start = -1;
    aresetn = 1'b1;
    t_rel = cyc;
    repeat (30) tick();
    tests_run++;
    if (n_starts !== 0 || bus.state_o !== 3'd0) begin
      fails++;
      $display("FAIL busy_hold: %0d starts state_o=%0d while busy held, need 0 0", n_starts, bus.state_o);
    end
    m_hold = 1'b0;
    wait_state(3'd5, 200, "busy_hold_idle");
    tests_run++;
    if (first_start - t_rel < 30 || n_starts !== 4 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL busy_hold_release: first start at %0d, %0d starts, need >=30 and 4", first_start - t_rel, n_starts);
    end
  endtask

  task automatic test_write();
    int c0;
    wait_state(3'd5, 50, "write_idle");
    c0 = n_starts;
    issue_cmd(1'b0, 16'h0003, 16'h0055);
    tests_run++;
    if (bus.cmd_ready !== 1'b0 || n_starts !== c0 + 1) begin
      fails++;
      $display("FAIL write_latency: cmd_ready=%b starts=%0d, need 0 and %0d", bus.cmd_ready, n_starts, c0 + 1);
    end
    wait_state(3'd5, 50, "write_return");
    tests_run++;
    if (bus.cmd_ready !== 1'b1 || bus.done_o !== 1'b1 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL write_return: cmd_ready=%b done_o=%b queue=%0d, need 1 1 0", bus.cmd_ready, bus.done_o, exp_q.size());
    end
  endtask

  task automatic test_read();
    int r0;
    bus.spi_rd_dat = 16'hA5C3;
    rd_q.push_back(16'hA5C3);
    r0 = n_rd;
    issue_cmd(1'b1, 16'h0012, 16'h0000);
    wait_state(3'd5, 50, "read_return");
    repeat (3) tick();
    bus.spi_rd_dat = 16'h0000;
    tests_run++;
    if (n_rd !== r0 + 1 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_pulse: %0d strobes, rd_valid=%b, need 1 and 0", n_rd - r0, bus.rd_valid);
    end
    tests_run++;
    if (bus.rd_dat !== 16'hA5C3 || bus.done_o !== 1'b1) begin
      fails++;
      $display("FAIL read_hold: rd_dat=%h done_o=%b need a5c3 1", bus.rd_dat, bus.done_o);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = n_rd;
    for (int i = 0; i < 4; i++) begin
      wait_state(3'd5, 50, "b2b_idle");
      issue_cmd(1'b0, 16'($urandom), 16'($urandom));
    end
    wait_state(3'd5, 50, "b2b_return");
    tests_run++;
    if (exp_q.size() !== 0 || n_rd !== r0 || bus.rd_dat !== 16'hA5C3) begin
      fails++;
      $display("FAIL b2b: queue=%0d strobes=%0d rd_dat=%h need 0 0 a5c3", exp_q.size(), n_rd - r0, bus.rd_dat);
    end
  endtask

  task automatic test_reinit();
    int c0, t0;
    wait_state(3'd5, 50, "reinit_idle");
    push_table();
    c0 = n_starts;
    first_start = -1;
    t0 = cyc;
    bus.reinit = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_adr = 16'h0099;
    bus.cmd_dat = 16'h0001;
    bus.cmd_rw = 1'b0;
    tick();
    bus.reinit = 1'b0;
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (bus.done_o !== 1'b0 || bus.state_o !== 3'd1 || bus.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reinit_entry: done_o=%b state_o=%0d cmd_ready=%b need 0 1 0", bus.done_o, bus.state_o, bus.cmd_ready);
    end
    wait_state(3'd5, 100, "reinit_idle_again");
    tests_run++;
    if (first_start - t0 > 3 || n_starts !== c0 + 4 || exp_q.size() !== 0 || bus.done_o !== 1'b1) begin
      fails++;
      $display("FAIL reinit_replay: first start +%0d, %0d starts, queue=%0d done_o=%b, need <=3 4 0 1",
               first_start - t0, n_starts - c0, exp_q.size(), bus.done_o);
    end
  endtask

`ifdef SPI_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int c0;
    wait_state(3'd5, 50, "timeout_idle");
    m_never = 1'b1;
    issue_cmd(1'b0, 16'h0021, 16'h0042);
    repeat (8) tick();
    tests_run++;
    if (bus.state_o !== 3'd3 || bus.err_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: state_o=%0d err_o=%b need 3 0", bus.state_o, bus.err_o);
    end
    tick();
    tests_run++;
    if (bus.state_o !== 3'd6 || bus.err_o !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.spi_start_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err: state_o=%0d err_o=%b ready=%b start=%b need 6 1 0 0",
               bus.state_o, bus.err_o, bus.cmd_ready, bus.spi_start_o);
    end
    m_never = 1'b0;
    push_table();
    c0 = n_starts;
    bus.reinit = 1'b1;
    tick();
    bus.reinit = 1'b0;
    tests_run++;
    if (bus.err_o !== 1'b0 || bus.state_o !== 3'd1) begin
      fails++;
      $display("FAIL timeout_reinit: err_o=%b state_o=%0d need 0 1", bus.err_o, bus.state_o);
    end
    wait_state(3'd5, 100, "timeout_recover");
    tests_run++;
    if (n_starts !== c0 + 4 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL timeout_replay: %0d starts queue=%0d need 4 0", n_starts - c0, exp_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid_xfer();
    wait_state(3'd5, 50, "midreset_idle");
    issue_cmd(1'b0, 16'h0030, 16'h0077);
    wait_state(3'd4, 10, "midreset_xfer");
    aresetn = 1'b0;
    tick();
    tests_run++;
    if ({bus.spi_start_o, bus.cmd_ready, bus.rd_valid, bus.done_o, bus.err_o, bus.state_o} !== 8'h00 ||
        {bus.spi_adr, bus.spi_dat, bus.spi_rw, bus.rd_dat} !== 49'h0) begin
      fails++;
      $display("FAIL midreset: start/ready/rdv/done/err/state=%b adr=%h dat=%h rw=%b rd_dat=%h need all 0",
               {bus.spi_start_o, bus.cmd_ready, bus.rd_valid, bus.done_o, bus.err_o, bus.state_o},
               bus.spi_adr, bus.spi_dat, bus.spi_rw, bus.rd_dat);
    end
  endtask

  initial begin
    aresetn        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_adr    = '0;
    bus.cmd_dat    = '0;
    bus.cmd_rw     = 1'b0;
    bus.reinit     = 1'b0;
    bus.spi_rd_dat = '0;
    test_reset();
    test_powerup();
    test_busy_hold();
    test_write();
    test_read();
    test_back_to_back();
    test_reinit();
`ifdef SPI_CFG_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
